// File: rtl/led_group_ctrl_if.sv
// Pin-side bundle of the LED group controller: raw switches and buttons in,
// LED value, group enables and press strobes out.
interface led_group_ctrl_if;
    localparam int unsigned SWT_W = 16;
    localparam int unsigned BTN_W = 4;

    logic [SWT_W-1:0] swt;
    logic [BTN_W-1:0] btn;
    logic [SWT_W-1:0] led;
    logic [BTN_W-1:0] grp_en;
    logic [BTN_W-1:0] press_pulse;

    modport master (output swt, output btn, input led, input grp_en, input press_pulse);
    modport slave  (input swt, input btn, output led, output grp_en, output press_pulse);
endinterface

// File: rtl/led_group_ctrl.sv
// Synchronises switches and buttons, debounces each button and lets every
// accepted press toggle the enable of its 4-bit LED group.
module led_group_ctrl #(
    parameter int unsigned DB_CYCLES = 500000,
    parameter int unsigned CNT_W     = 20
) (
    input  logic            clk,
    input  logic            rst,
    led_group_ctrl_if.slave bus
);
    localparam int unsigned SWT_W = 16;
    localparam int unsigned N_BTN = 4;
    localparam int unsigned GRP_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } db_state_t;

    logic [SWT_W-1:0] swt_m, swt_s;
    logic [N_BTN-1:0] btn_m, btn_s;
    db_state_t        state_q [N_BTN];
    db_state_t        state_d [N_BTN];
    logic [CNT_W-1:0] cnt_q   [N_BTN];
    logic [CNT_W-1:0] cnt_d   [N_BTN];
    logic [N_BTN-1:0] pulse_q, pulse_d;
    logic [N_BTN-1:0] grp_en_q;
    logic [SWT_W-1:0] led_mask;

    // State register: synchronisers, debouncers, strobes and group enables
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            swt_m    <= '0;
            swt_s    <= '0;
            btn_m    <= '0;
            btn_s    <= '0;
            pulse_q  <= '0;
            grp_en_q <= '1;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            swt_m    <= bus.swt;
            swt_s    <= swt_m;
            btn_m    <= bus.btn;
            btn_s    <= btn_m;
            pulse_q  <= pulse_d;
            grp_en_q <= grp_en_q ^ pulse_q;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Per-button debounce: a level must hold for DB_CYCLES samples to be believed
    always_comb begin
        pulse_d = '0;
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (btn_s[i]) begin
                        state_d[i] = PRESS_WAIT;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = HELD;
                        cnt_d[i]   = '0;
                        pulse_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!btn_s[i]) begin
                        state_d[i] = REL_WAIT;
                        cnt_d[i]   = CNT_ONE;
                    end
                end
                REL_WAIT: begin
                    if (btn_s[i]) begin
                        state_d[i] = HELD;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Expand each group enable over its four LEDs
    always_comb begin
        led_mask = '0;
        for (int i = 0; i < N_BTN; i++) begin
            led_mask[GRP_W*i +: GRP_W] = {GRP_W{grp_en_q[i]}};
        end
    end

    assign bus.led         = swt_s & led_mask;
    assign bus.grp_en      = grp_en_q;
    assign bus.press_pulse = pulse_q;

endmodule

// File: tb/tb_led_group_ctrl.sv
// Bench for led_group_ctrl: directed scenarios plus random button/switch
// activity, all checked every cycle against a stable-run reference model.
module tb_led_group_ctrl;
    localparam int unsigned DB = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    led_group_ctrl_if bus ();

    led_group_ctrl #(.DB_CYCLES(DB), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt [4];
    logic [3:0] last_pulse;

    // Reference: a press is a run of DB high samples while released,
    // a release is a run of DB low samples while held.
    logic [15:0] m_swt_m, m_swt_s;
    logic [3:0]  m_btn_m, m_btn_s;
    logic [3:0]  m_grp, m_pulse, m_held;
    int          run_hi [4];
    int          run_lo [4];

    always @(posedge clk) begin
        logic [3:0] np;
        if (rst) begin
            m_swt_m = '0; m_swt_s = '0; m_btn_m = '0; m_btn_s = '0;
            m_grp = 4'hF; m_pulse = '0; m_held = '0;
            for (int i = 0; i < 4; i++) begin run_hi[i] = 0; run_lo[i] = 0; end
        end else begin
            np = '0;
            for (int i = 0; i < 4; i++) begin
                if (m_btn_s[i]) begin
                    if (run_hi[i] < 1000) run_hi[i]++;
                    run_lo[i] = 0;
                end else begin
                    if (run_lo[i] < 1000) run_lo[i]++;
                    run_hi[i] = 0;
                end
                if (!m_held[i] && run_hi[i] == DB) begin
                    np[i] = 1'b1;
                    m_held[i] = 1'b1;
                end else if (m_held[i] && run_lo[i] == DB) begin
                    m_held[i] = 1'b0;
                end
            end
            m_grp   = m_grp ^ m_pulse;
            m_pulse = np;
            m_swt_s = m_swt_m;
            m_swt_m = bus.swt;
            m_btn_s = m_btn_m;
            m_btn_m = bus.btn;
        end
    end

    function automatic logic [15:0] exp_led();
        logic [15:0] v = '0;
        for (int i = 0; i < 4; i++)
            if (m_grp[i]) v[4*i +: 4] = m_swt_s[4*i +: 4];
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance n cycles, comparing DUT to model at each falling edge
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("led", 32'(bus.led), 32'(exp_led()));
            check("grp_en", 32'(bus.grp_en), 32'(m_grp));
            check("press_pulse", 32'(bus.press_pulse), 32'(m_pulse));
            for (int i = 0; i < 4; i++) if (bus.press_pulse[i]) pulse_cnt[i]++;
            if (bus.press_pulse != 4'h0) last_pulse = bus.press_pulse;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        int c0;
        for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;
        last_pulse = '0;
        bus.swt = 16'hF0A5;
        bus.btn = 4'h0;
        #2 rst = 1'b1;
        #1;
        check("rst_led", 32'(bus.led), 32'h0);
        check("rst_grp_en", 32'(bus.grp_en), 32'hF);
        check("rst_pulse", 32'(bus.press_pulse), 32'h0);
        step(2);
        rst = 1'b0;
        step(2);
        check("t1_led", 32'(bus.led), 32'hF0A5);
        step(4);
        check("t1_grp_en", 32'(bus.grp_en), 32'hF);
        check("t1_pulses", 32'(pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3]), 32'h0);

        // Single press of button 0
        bus.btn = 4'b0001;
        step(8);
        check("t2_led_8cyc", 32'(bus.led), 32'hF0A0);
        step(12);
        bus.btn = 4'b0000;
        step(10);
        check("t2_pulse_cnt", 32'(pulse_cnt[0]), 32'd1);
        check("t2_grp_en", 32'(bus.grp_en), 32'hE);

        // Bounce on button 2, then a genuine hold
        c0 = pulse_cnt[2];
        bus.btn = 4'b0100; step(2);
        bus.btn = 4'b0000; step(3);
        bus.btn = 4'b0100; step(2);
        bus.btn = 4'b0000; step(8);
        check("t3_bounce_cnt", 32'(pulse_cnt[2] - c0), 32'd0);
        check("t3_bounce_grp", 32'(bus.grp_en), 32'hE);
        bus.btn = 4'b0100; step(10);
        bus.btn = 4'b0000; step(8);
        check("t3_hold_cnt", 32'(pulse_cnt[2] - c0), 32'd1);
        check("t3_hold_grp", 32'(bus.grp_en), 32'hA);

        // All four buttons together
        do_reset();
        bus.swt = 16'hFFFF;
        last_pulse = '0;
        bus.btn = 4'b1111; step(10);
        check("t4_same_cycle", 32'(last_pulse), 32'hF);
        check("t4_grp_off", 32'(bus.grp_en), 32'h0);
        check("t4_led_off", 32'(bus.led), 32'h0);
        bus.btn = 4'b0000; step(8);
        bus.btn = 4'b1111; step(10);
        bus.btn = 4'b0000; step(8);
        check("t4_grp_on", 32'(bus.grp_en), 32'hF);
        check("t4_led_on", 32'(bus.led), 32'hFFFF);

        // Reset while button 1 is held
        bus.btn = 4'b0010; step(10);
        check("t5_pre_grp", 32'(bus.grp_en), 32'hD);
        c0 = pulse_cnt[1];
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_rst_grp", 32'(bus.grp_en), 32'hF);
        step(1);
        rst = 1'b0;
        step(10);
        check("t5_repress_cnt", 32'(pulse_cnt[1] - c0), 32'd1);
        check("t5_repress_grp", 32'(bus.grp_en), 32'hD);
        bus.btn = 4'b0000; step(8);

        // Long hold on button 3 with a one-cycle dropout
        c0 = pulse_cnt[3];
        bus.btn = 4'b1000; step(100);
        bus.btn = 4'b0000; step(1);
        bus.btn = 4'b1000; step(99);
        bus.btn = 4'b0000; step(8);
        check("t6_glitch_cnt", 32'(pulse_cnt[3] - c0), 32'd1);
        check("t6_glitch_grp", 32'(bus.grp_en), 32'h5);

        // Random buttons, switches and occasional resets
        for (int seg = 0; seg < 400; seg++) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            bus.btn = 4'($urandom);
            if ($urandom_range(0, 3) == 0) bus.swt = 16'($urandom);
            step(int'($urandom_range(1, 9)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/led_group_ctrl.md
Name: led_group_ctrl

Overview:
Sequential controller for the board-level switch-to-LED datapath on the Nexys4 top.
- Synchronises and debounces the 4 push-buttons.
- Each accepted press toggles the enable of one 4-bit LED group.
- LEDs show the synchronised switch value masked by the group enables.
- Sits between the raw board pins (swt, btn) and the led outputs, replacing any direct combinational gating.

Parameters:
DB_CYCLES, 500000, consecutive stable synchronised samples needed to accept a press or release (5 ms at 100 MHz); benches override to 4.
CNT_W, 20, debounce counter width; must satisfy 2**CNT_W > DB_CYCLES.

Ports:
clk  input  1  system clock (100 MHz on board)
rst  input  1  reset; one clock; reset is asynchronous and active-high
swt  input  16  raw slide switches, asynchronous to clk
btn  input  4  raw push-buttons, asynchronous to clk, 1 = pressed
led  output  16  displayed value; led[4i+3:4i] belongs to group i
grp_en  output  4  current group enables; bit i drives led[4i+3:4i]
press_pulse  output  4  one-cycle strobe per button on each accepted press

Behaviour:
Reset (rst=1, async):
- All synchroniser flops, counters and press_pulse clear to 0.
- All debouncers go to IDLE.
- grp_en = 4'b1111.
- led = 0, since the synchronised swt is 0.

Synchronisers:
- swt and btn each pass through a 2-flop synchroniser, giving swt_s and btn_s.
- No further filtering on swt.

Debouncer, one independent instance per button i, 4 states:
- IDLE: cnt=0. btn_s[i]=1 -> PRESS_WAIT with cnt=1.
- PRESS_WAIT: btn_s[i]=0 -> IDLE, cnt=0. Else if cnt==DB_CYCLES-1 -> HELD and assert press_pulse[i] for exactly that transition cycle. Else cnt++.
- HELD: btn_s[i]=0 -> REL_WAIT with cnt=1. No repeat pulses while held, however long.
- REL_WAIT: btn_s[i]=1 -> HELD, cnt=0, no new pulse. Else if cnt==DB_CYCLES-1 -> IDLE. Else cnt++.

Net effect: a press is accepted after btn_s[i] has been high for DB_CYCLES consecutive edges. Any glitch shorter than that produces no pulse.

press_pulse:
- Registered output.
- High for one cycle on the edge that enters HELD.

Group enables:
- grp_en[i] toggles on the clock edge after press_pulse[i]=1.
- Simultaneous pulses on several buttons toggle every affected bit independently in the same cycle.
- No priority between buttons.

LED output:
- led = swt_s & {{4{grp_en[3]}},{4{grp_en[2]}},{4{grp_en[1]}},{4{grp_en[0]}}}.
- Combinational from registers only; no path from raw pins to led.

Latency:
- swt change to led change: 2 cycles.
- btn rising edge (held stable) to grp_en toggle: 2 + DB_CYCLES + 1 cycles, ±1 for pin/clock phase.

Counter:
- Saturates at DB_CYCLES-1 by construction; never wraps.

Reset mid-operation:
- Any state, including HELD with the button still down, returns to IDLE and grp_en=1111.
- A button still held after rst deasserts is treated as a new press once stable for DB_CYCLES, and toggles its group.

Test Plan:
(DB_CYCLES=4 throughout)
1. Reset then swt=16'hF0A5, btn=0 -> led=0 during reset; led=16'hF0A5 two cycles after release; grp_en=4'b1111; press_pulse stays 0.
2. swt=16'hF0A5; hold btn=4'b0001 for 20 cycles then release -> exactly one press_pulse[0]; grp_en=4'b1110; led=16'hF0A0 within 8 cycles of press; no further change after release.
3. btn[2] high for 2 cycles, low 3, high 2 (bounce) -> no press_pulse; grp_en unchanged. Then hold 10 cycles -> single pulse; grp_en[2] toggles.
4. From grp_en=1111, swt=16'hFFFF: btn=4'b1111 held 10 cycles -> press_pulse=1111 in the same cycle; grp_en=0000; led=0. Release >=6 cycles, press again -> grp_en=1111; led=16'hFFFF.
5. Hold btn[1] with grp_en=1101; pulse rst mid-hold, keep btn[1] held -> grp_en=1111 immediately on rst; after rst release plus about 7 cycles one pulse; grp_en=1101.
6. Hold btn[3] 200 cycles with a 1-cycle low glitch at cycle 100 -> exactly one press_pulse[3] and grp_en[3] toggled once.
